activity_session_ctrl: RTL and testbench

Session controller for the fitness-tracker datapath. Generates the 1 s tick and measures pulses per second from the pulse sensor. Qualifies high-activity seconds and maintains the high-activity-time accumulator. Also sequences the display-mode rotation consumed by the seven-segment mux.

---
 rtl/activity_pkg.sv | 23 ++
 rtl/tick_gen.sv | 31 +++
 rtl/activity_session_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_activity_session_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/activity_pkg.sv
// Shared types and constants for the activity session controller.
package activity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Display rotation order consumed by the seven-segment mux
    localparam logic [1:0] MODE_STEPS  = 2'd0;
    localparam logic [1:0] MODE_DIST   = 2'd1;
    localparam logic [1:0] MODE_OVER32 = 2'd2;
    localparam logic [1:0] MODE_HAT    = 2'd3;

    localparam int HI_THRESH_DEF = 64;
    localparam int QUAL_SEC_DEF  = 60;

    function automatic logic [1:0] next_mode(input logic [1:0] m);
        return (m == MODE_HAT) ? MODE_STEPS : m + 2'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second tick divider: counts 0..TICK_DIV-1 while enabled, holds its value otherwise.
module tick_gen #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_LAST);
    assign o_tick = i_en && w_last;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/activity_session_ctrl.sv
// Session controller: 1 s tick, pulse-rate window, high-activity qualification and display rotation.
// Optional build macro HAT_SAT_EN makes the high-activity-time accumulator saturate instead of wrap.
module activity_session_ctrl
    import activity_pkg::*;
#(
    parameter int TICK_DIV  = 100000000,
    parameter int RATE_W    = 10,
    parameter int HI_THRESH = HI_THRESH_DEF,
    parameter int QUAL_SEC  = QUAL_SEC_DEF,
    parameter int HAT_W     = 16,
    parameter int ROT_SEC   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    output logic              tick,
    output logic [RATE_W-1:0] rate,
    output logic [HAT_W-1:0]  hat,
    output logic [6:0]        streak,
    output logic [1:0]        mode,
    output logic              running
);

    localparam int SEC_W = (ROT_SEC > 1) ? $clog2(ROT_SEC) : 1;
    localparam logic [SEC_W-1:0]  ROT_LAST    = SEC_W'(ROT_SEC - 1);
    localparam logic [RATE_W-1:0] RATE_MAX    = '1;
    localparam logic [RATE_W-1:0] HI_TH       = RATE_W'(HI_THRESH);
    localparam logic [6:0]        STREAK_QUAL = 7'(QUAL_SEC);
    localparam logic [6:0]        STREAK_PRE  = 7'(QUAL_SEC - 1);
    localparam logic [HAT_W-1:0]  CREDIT_QUAL = HAT_W'(QUAL_SEC);
    localparam logic [HAT_W-1:0]  CREDIT_ONE  = HAT_W'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_pulse_prev;
    logic [RATE_W-1:0] r_window;
    logic [RATE_W-1:0] r_rate;
    logic [HAT_W-1:0]  r_hat;
    logic [6:0]        r_streak;
    logic [1:0]        r_mode;
    logic [SEC_W-1:0]  r_sec_cnt;

    logic              w_run;
    logic              w_clear;
    logic              w_stop;
    logic              w_tick;
    logic              w_edge;
    logic              w_high;
    logic [6:0]        w_streak_next;
    logic [HAT_W-1:0]  w_credit;
    logic [HAT_W-1:0]  w_hat_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // stop outranks start, start outranks pause
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start && !stop) w_state_next = RUN;
            RUN: begin
                if (stop)       w_state_next = IDLE;
                else if (pause) w_state_next = HOLD;
            end
            HOLD: begin
                if (stop)       w_state_next = IDLE;
                else if (pause) w_state_next = RUN;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_run   = (r_state == RUN);
    assign w_clear = (r_state == IDLE) && (w_state_next == RUN);
    assign w_stop  = (r_state != IDLE) && stop;
    assign w_edge  = w_run && pulse_in && !r_pulse_prev;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .i_rst_n (reset),
        .i_en    (w_run),
        .i_clr   (w_clear),
        .o_tick  (w_tick)
    );

    // An edge on the tick cycle opens the new window rather than closing the old one
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pulse_prev <= 1'b0;
            r_window     <= '0;
        end else begin
            r_pulse_prev <= pulse_in;
            if (w_clear) begin
                r_window <= '0;
            end else if (w_tick) begin
                r_window <= w_edge ? RATE_W'(1) : '0;
            end else if (w_edge && (r_window != RATE_MAX)) begin
                r_window <= r_window + RATE_W'(1);
            end
        end
    end

    assign w_high = (r_window >= HI_TH);

    always_comb begin
        w_streak_next = r_streak;
        w_credit      = '0;
        if (w_high) begin
            if (r_streak < STREAK_PRE) begin
                w_streak_next = r_streak + 7'd1;
            end else if (r_streak == STREAK_PRE) begin
                w_streak_next = STREAK_QUAL;
                w_credit      = CREDIT_QUAL;
            end else begin
                w_credit      = CREDIT_ONE;
            end
        end else begin
            w_streak_next = '0;
        end
    end

`ifdef HAT_SAT_EN
    logic [HAT_W:0] w_hat_sum;
    assign w_hat_sum  = {1'b0, r_hat} + {1'b0, w_credit};
    assign w_hat_next = w_hat_sum[HAT_W] ? '1 : w_hat_sum[HAT_W-1:0];
`else
    assign w_hat_next = r_hat + w_credit;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rate    <= '0;
            r_hat     <= '0;
            r_streak  <= '0;
            r_mode    <= MODE_STEPS;
            r_sec_cnt <= '0;
        end else if (w_clear) begin
            r_rate    <= '0;
            r_hat     <= '0;
            r_streak  <= '0;
            r_mode    <= MODE_STEPS;
            r_sec_cnt <= '0;
        end else begin
            if (w_tick) begin
                r_rate   <= r_window;
                r_streak <= w_streak_next;
                r_hat    <= w_hat_next;
            end
            // Leaving the session parks the display on the first mode
            if (w_stop) begin
                r_mode    <= MODE_STEPS;
                r_sec_cnt <= '0;
            end else if (w_tick) begin
                if (r_sec_cnt == ROT_LAST) begin
                    r_sec_cnt <= '0;
                    r_mode    <= next_mode(r_mode);
                end else begin
                    r_sec_cnt <= r_sec_cnt + SEC_W'(1);
                end
            end
        end
    end

    assign tick    = w_tick;
    assign rate    = r_rate;
    assign hat     = r_hat;
    assign streak  = r_streak;
    assign mode    = r_mode;
    assign running = (r_state != IDLE);

endmodule

// File: tb/tb_activity_session_ctrl.sv
// Directed bench for activity_session_ctrl: table of per-second segments plus pause/stop/reset sequences.
module tb_activity_session_ctrl;

    localparam int TICK_DIV  = 12;
    localparam int RATE_W    = 10;
    localparam int HI_THRESH = 4;
    localparam int QUAL_SEC  = 60;
    localparam int HAT_W     = 7;
    localparam int ROT_SEC   = 2;
    localparam int NVEC      = 14;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              pulse_in = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              pause = 1'b0;
    logic              tick;
    logic [RATE_W-1:0] rate;
    logic [HAT_W-1:0]  hat;
    logic [6:0]        streak;
    logic [1:0]        mode;
    logic              running;

    int total = 0;
    int bad   = 0;

    // Pulse level per divider phase (bit n = level during phase n)
    logic [11:0] p4   = 12'h055;  // 4 edges
    logic [11:0] p3   = 12'h015;  // 3 edges
    logic [11:0] pt3  = 12'h955;  // 5 edges, then one on the tick cycle
    logic [11:0] pnx  = 12'h014;  // 2 edges after a tick-cycle edge

    typedef struct {
        int          nsec;
        logic [11:0] pat;
        int          rate;
        int          streak;
        int          hat_w;
        int          hat_s;
        int          mode;
    } vec_t;

    vec_t vec [NVEC];

    activity_session_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .RATE_W    (RATE_W),
        .HI_THRESH (HI_THRESH),
        .QUAL_SEC  (QUAL_SEC),
        .HAT_W     (HAT_W),
        .ROT_SEC   (ROT_SEC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .tick     (tick),
        .rate     (rate),
        .hat      (hat),
        .streak   (streak),
        .mode     (mode),
        .running  (running)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int pick_hat(input int w, input int s);
`ifdef HAT_SAT_EN
        return s;
`else
        return w;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // One clock: drive inputs, sample tick mid-cycle, then advance past the edge
    task automatic step(input logic p, input logic st, input logic sp, input logic pa, output logic tk);
        pulse_in = p;
        start    = st;
        stop     = sp;
        pause    = pa;
        #2;
        tk = tick;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
    endtask

    task automatic run_row(input int i);
        logic tk;
        int   ticks;
        int   wrong;
        ticks = 0;
        wrong = 0;
        for (int s = 0; s < vec[i].nsec; s++) begin
            for (int ph = 0; ph < TICK_DIV; ph++) begin
                step(vec[i].pat[ph], 1'b0, 1'b0, 1'b0, tk);
                if (tk) begin
                    if (ph == TICK_DIV - 1) ticks++;
                    else                    wrong++;
                end
            end
        end
        chk($sformatf("row%0d_ticks", i), ticks, vec[i].nsec);
        chk($sformatf("row%0d_tick_phase", i), wrong, 0);
        chk($sformatf("row%0d_rate", i), rate, vec[i].rate);
        chk($sformatf("row%0d_streak", i), streak, vec[i].streak);
        chk($sformatf("row%0d_hat", i), hat, pick_hat(vec[i].hat_w, vec[i].hat_s));
        chk($sformatf("row%0d_mode", i), mode, vec[i].mode);
        chk($sformatf("row%0d_running", i), running, 1);
    endtask

    initial begin
        logic tk;
        int   ticks;
        int   early;
        int   at_last;
        int   hat_end;

        // nsec, pattern, rate, streak, hat(wrap), hat(sat), mode
        vec[0]  = '{59, p4,  4, 59,   0,   0, 1};
        vec[1]  = '{ 1, p4,  4, 60,  60,  60, 2};
        vec[2]  = '{10, p4,  4, 60,  70,  70, 3};
        vec[3]  = '{30, p4,  4, 60, 100, 100, 2};
        vec[4]  = '{ 1, p3,  3,  0, 100, 100, 2};
        vec[5]  = '{59, p4,  4, 59, 100, 100, 0};
        vec[6]  = '{ 1, p4,  4, 60,  32, 127, 0};
        vec[7]  = '{ 1, p4,  4, 60,  33, 127, 1};
        vec[8]  = '{ 1, pt3, 5, 60,  34, 127, 1};
        vec[9]  = '{ 1, pnx, 3,  0,  34, 127, 2};
        vec[10] = '{59, p4,  4, 59,   0,   0, 1};
        vec[11] = '{ 1, p3,  3,  0,   0,   0, 2};
        vec[12] = '{59, p4,  4, 59,   0,   0, 3};
        vec[13] = '{ 1, p4,  4, 60,  60,  60, 0};
        hat_end = pick_hat(34, 127);

        // Power-up reset
        reset = 1'b0;
        ticks = 0;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, tk);
        end
        chk("rst_tick", tick, 0);
        chk("rst_rate", rate, 0);
        chk("rst_hat", hat, 0);
        chk("rst_streak", streak, 0);
        chk("rst_mode", mode, 0);
        chk("rst_running", running, 0);
        reset = 1'b1;

        step(1'b0, 1'b1, 1'b0, 1'b0, tk);
        chk("start1_running", running, 1);

        for (int i = 0; i < 10; i++) begin
            run_row(i);
        end

        // Pause mid-second: divider freezes at phase 6, toggling pulses are ignored
        ticks = 0;
        for (int ph = 0; ph < 5; ph++) begin
            step(p4[ph], 1'b0, 1'b0, 1'b0, tk);
            ticks += int'(tk);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, tk);
        ticks += int'(tk);
        for (int c = 0; c < 3 * TICK_DIV; c++) begin
            step((c % 2) == 0, 1'b0, 1'b0, 1'b0, tk);
            ticks += int'(tk);
        end
        chk("hold_tick", ticks, 0);
        chk("hold_running", running, 1);
        chk("hold_rate", rate, 3);
        chk("hold_streak", streak, 0);
        chk("hold_hat", hat, hat_end);
        step(1'b0, 1'b0, 1'b0, 1'b1, tk);
        early   = int'(tk);
        at_last = 0;
        for (int ph = 6; ph < TICK_DIV; ph++) begin
            step(p4[ph], 1'b0, 1'b0, 1'b0, tk);
            if (tk) begin
                if (ph == TICK_DIV - 1) at_last++;
                else                    early++;
            end
        end
        chk("resume_tick_last", at_last, 1);
        chk("resume_tick_early", early, 0);
        chk("resume_rate", rate, 4);
        chk("resume_streak", streak, 1);
        chk("resume_hat", hat, hat_end);
        chk("resume_mode", mode, 2);

        // start together with stop in RUN: stop wins, results held
        step(1'b0, 1'b1, 1'b1, 1'b0, tk);
        chk("stop_running", running, 0);
        chk("stop_hat", hat, hat_end);
        chk("stop_rate", rate, 4);
        chk("stop_streak", streak, 1);
        chk("stop_mode", mode, 0);
        ticks = 0;
        for (int c = 0; c < 2 * TICK_DIV; c++) begin
            step((c % 2) == 0, 1'b0, 1'b0, 1'b0, tk);
            ticks += int'(tk);
        end
        chk("idle_tick", ticks, 0);
        chk("idle_rate", rate, 4);

        step(1'b0, 1'b1, 1'b0, 1'b0, tk);
        chk("start2_running", running, 1);
        chk("start2_hat", hat, 0);
        chk("start2_rate", rate, 0);
        chk("start2_streak", streak, 0);
        chk("start2_mode", mode, 0);

        for (int i = 10; i < NVEC; i++) begin
            run_row(i);
        end

        // Reset in the middle of a session
        for (int ph = 0; ph < 5; ph++) begin
            step(p4[ph], 1'b0, 1'b0, 1'b0, tk);
        end
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, tk);
        reset = 1'b1;
        chk("mrst_running", running, 0);
        chk("mrst_rate", rate, 0);
        chk("mrst_hat", hat, 0);
        chk("mrst_streak", streak, 0);
        chk("mrst_mode", mode, 0);
        ticks = 0;
        for (int c = 0; c < 2 * TICK_DIV; c++) begin
            step((c % 2) == 0, 1'b0, 1'b0, 1'b0, tk);
            ticks += int'(tk);
        end
        chk("mrst_tick", ticks, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
